// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
//
// Holds the fetch PC, drives the I-cache request, waits out cache misses and
// hazard stalls, and buffers one branch/jump redirect that arrives while the
// current access has not yet completed. Completed, non-squashed fetches are
// reported to the IF/ID register as if_valid_o / if_pc4_o.
//
// Optional build macro: PERF_CNT_EN adds miss_cycles_o, a saturating count
// of cycles spent in MISS_WAIT.
//
// Ports:
//   clk_i               clock, rising edge
//   rst_i               asynchronous active-low reset
//   stall_i             hazard stall, blocks fetch completion
//   branch_i            taken-branch pulse from EX
//   branch_pc4_i        PC+4 of the branch
//   branch_offset_i     sign-extended offset, already shifted left 2
//   jump_i              jump pulse from EX (wins over branch)
//   jump_target_i       jump target address
//   icache_ready_i      I-cache returns data for the current request
//   icache_req_o        fetch request for pc_o
//   pc_o                current fetch PC
//   if_valid_o          previous cycle completed a non-squashed fetch
//   if_pc4_o            PC+4 of the instruction flagged by if_valid_o
//   redirect_pending_o  a redirect is buffered, awaiting completion
//   miss_cycles_o       (PERF_CNT_EN only) miss-cycle counter
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc4_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        icache_ready_i,
    output logic        icache_req_o,
    output logic [31:0] pc_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc4_o,
    output logic        redirect_pending_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] miss_cycles_o
`endif
);

    typedef enum logic {FETCH, MISS_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc4_q, pc4_d;
    logic        pend_q, pend_d;
    logic [31:0] ptgt_q, ptgt_d;

    logic        redir;
    logic [31:0] redir_tgt;
    logic        complete;
    logic [31:0] pc_plus4;

    // Request is high whenever the block is out of reset, in either state.
    assign icache_req_o = rst_i;
    assign complete     = icache_req_o & icache_ready_i & ~stall_i;
    assign pc_plus4     = pc_q + 32'd4;
    assign redir        = jump_i | branch_i;
    assign redir_tgt    = jump_i ? (jump_target_i & 32'hFFFF_FFFC)
                                 : ((branch_pc4_i + branch_offset_i) & 32'hFFFF_FFFC);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            pc4_q   <= 32'h0;
            pend_q  <= 1'b0;
            ptgt_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        pc4_d   = pc4_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;

        unique case (state_q)
            FETCH:     if (!icache_ready_i) state_d = MISS_WAIT;
            MISS_WAIT: if (icache_ready_i)  state_d = FETCH;
            default:   state_d = FETCH;
        endcase

        if (complete) begin
            // A redirect (live or buffered) squashes the instruction just fetched.
            if (redir) begin
                pc_d = redir_tgt;
            end else if (pend_q) begin
                pc_d = ptgt_q;
            end else begin
                pc_d    = pc_plus4;
                valid_d = 1'b1;
                pc4_d   = pc_plus4;
            end
            pend_d = 1'b0;
        end else if (redir) begin
            // Access still in flight: remember the newest target until it completes.
            pend_d = 1'b1;
            ptgt_d = redir_tgt;
        end
    end

    assign pc_o               = pc_q;
    assign if_valid_o         = valid_q;
    assign if_pc4_o           = pc4_q;
    assign redirect_pending_o = pend_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == MISS_WAIT && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign miss_cycles_o = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch, jump, ready;
    logic [31:0] bpc4, boff, jtgt;
    logic        req, valid, pend;
    logic [31:0] pc, pc4;
`ifdef PERF_CNT_EN
    logic [31:0] miss_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: architectural view of the fetch unit.
    logic [31:0] m_pc, m_pc4, m_ptgt, m_cnt;
    logic        m_valid, m_pend, m_in_miss;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall),
        .branch_i(branch), .branch_pc4_i(bpc4), .branch_offset_i(boff),
        .jump_i(jump), .jump_target_i(jtgt), .icache_ready_i(ready),
        .icache_req_o(req), .pc_o(pc), .if_valid_o(valid), .if_pc4_o(pc4),
        .redirect_pending_o(pend)
`ifdef PERF_CNT_EN
        , .miss_cycles_o(miss_cnt)
`endif
    );

    task automatic model_reset();
        m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
        m_ptgt = 32'h0; m_cnt = 32'h0; m_in_miss = 1'b0;
    endtask

    // Advance one clock; model the architectural effect of the inputs held
    // during that cycle, then leave the bench 1 time unit past the edge.
    task automatic cycle();
        logic        fin, rd;
        logic [31:0] tgt;
        fin = rst_n & ready & ~stall;
        rd  = jump | branch;
        tgt = jump ? {jtgt[31:2], 2'b00} : ((bpc4 + boff) & ~32'd3);
        @(posedge clk); #1;
        if (m_in_miss && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_in_miss = ~ready;
        if (fin) begin
            m_valid = !(rd || m_pend);
            if (m_valid) m_pc4 = m_pc + 4;
            m_pc   = rd ? tgt : (m_pend ? m_ptgt : m_pc + 4);
            m_pend = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rd) begin m_pend = 1'b1; m_ptgt = tgt; end
        end
        branch = 1'b0; jump = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #1;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stall = 0; branch = 0; jump = 0; ready = 1;
        bpc4 = 0; boff = 0; jtgt = 0;
        rst_n = 1'b0; #2;
        model_reset();
        tests++; if (pc !== 32'h0)  begin fails++; $display("FAIL reset_pc got %h want 0", pc); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if (pc4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h want 0", pc4); end
        tests++; if (pend !== 1'b0) begin fails++; $display("FAIL reset_pend got %b want 0", pend); end
        tests++; if (req !== 1'b0)  begin fails++; $display("FAIL reset_req got %b want 0", req); end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++; if (req !== 1'b1)  begin fails++; $display("FAIL req_after_reset got %b want 1", req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        ready = 1;
        @(posedge clk); #1;  // re-align to post-edge sampling point
        // that edge completed the fetch of 0
        m_pc = 32'h4; m_pc4 = 32'h4; m_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (pc !== exp_pc[i] || valid !== 1'b1 || pc4 !== exp_pc[i])
                begin fails++; $display("FAIL seq[%0d] pc=%h v=%b pc4=%h want pc=pc4=%h v=1", i, pc, valid, pc4, exp_pc[i]); end
            if (i < 3) cycle();
        end
    endtask

    task automatic test_miss();
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (pc !== 32'h10 || req !== 1'b1 || valid !== 1'b0)
                begin fails++; $display("FAIL miss_hold[%0d] pc=%h req=%b v=%b want 10/1/0", i, pc, req, valid); end
        end
        ready = 1; cycle();
        tests++;
        if (pc !== 32'h14 || pc4 !== 32'h14 || valid !== 1'b1)
            begin fails++; $display("FAIL miss_done pc=%h pc4=%h v=%b want 14/14/1", pc, pc4, valid); end
`ifdef PERF_CNT_EN
        tests++;
        if (miss_cnt !== 32'd3) begin fails++; $display("FAIL miss_count got %0d want 3", miss_cnt); end
`endif
    endtask

    task automatic test_branch_complete();
        branch = 1; bpc4 = 32'h20; boff = 32'hFFFF_FFF0; cycle();
        tests++;
        if (pc !== 32'h10 || valid !== 1'b0)
            begin fails++; $display("FAIL branch_now pc=%h v=%b want 10/0", pc, valid); end
    endtask

    task automatic test_branch_in_miss();
        jump = 1; jtgt = 32'h8; cycle();
        ready = 0; cycle();
        branch = 1; bpc4 = 32'h30; boff = 32'h10; cycle();
        tests++;
        if (pend !== 1'b1 || pc !== 32'h8)
            begin fails++; $display("FAIL pend_set pend=%b pc=%h want 1/8", pend, pc); end
        cycle();
        tests++;
        if (pend !== 1'b1) begin fails++; $display("FAIL pend_hold got %b want 1", pend); end
        ready = 1; cycle();
        tests++;
        if (pc !== 32'h40 || valid !== 1'b0 || pend !== 1'b0)
            begin fails++; $display("FAIL pend_consume pc=%h v=%b pend=%b want 40/0/0", pc, valid, pend); end
        // Second redirect during a miss overwrites the first.
        ready = 0; cycle();
        jump = 1; jtgt = 32'h200; cycle();
        branch = 1; bpc4 = 32'h300; boff = 32'h4; cycle();
        ready = 1; cycle();
        tests++;
        if (pc !== 32'h304 || pend !== 1'b0)
            begin fails++; $display("FAIL pend_overwrite pc=%h pend=%b want 304/0", pc, pend); end
    endtask

    task automatic test_stall_priority();
        logic [31:0] held;
        held = pc; stall = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            tests++;
            if (pc !== held || req !== 1'b1 || valid !== 1'b0)
                begin fails++; $display("FAIL stall[%0d] pc=%h req=%b v=%b want %h/1/0", i, pc, req, valid, held); end
        end
        stall = 0;
        jump = 1; jtgt = 32'h103; branch = 1; bpc4 = 32'h500; boff = 32'h0; cycle();
        tests++;
        if (pc !== 32'h100) begin fails++; $display("FAIL jump_prio got %h want 100", pc); end
        jump = 1; jtgt = 32'hFFFF_FFFC; cycle();
        cycle();
        tests++;
        if (pc !== 32'h0 || valid !== 1'b1 || pc4 !== 32'h0)
            begin fails++; $display("FAIL wrap pc=%h v=%b pc4=%h want 0/1/0", pc, valid, pc4); end
    endtask

    task automatic test_async_reset();
        ready = 0; cycle();
        branch = 1; bpc4 = 32'h1000; boff = 32'h20; cycle();
        #3 rst_n = 1'b0; #1;
        tests++;
        if (pc !== 32'h0 || pend !== 1'b0 || req !== 1'b0)
            begin fails++; $display("FAIL async_reset pc=%h pend=%b req=%b want 0/0/0", pc, pend, req); end
        model_reset();
        ready = 1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_pc = 32'h4; m_pc4 = 32'h4; m_valid = 1'b1;
        tests++;
        if (pc !== 32'h4 || pend !== 1'b0 || valid !== 1'b1)
            begin fails++; $display("FAIL after_reset pc=%h pend=%b v=%b want 4/0/1", pc, pend, valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ready  = ($urandom_range(3) != 0);
            stall  = ($urandom_range(4) == 0);
            branch = ($urandom_range(7) == 0);
            jump   = ($urandom_range(9) == 0);
            bpc4   = $urandom; boff = $urandom; jtgt = $urandom;
            cycle();
            tests++;
            if (pc !== m_pc || valid !== m_valid || pend !== m_pend || req !== 1'b1 ||
                (m_valid && pc4 !== m_pc4))
                begin fails++; $display("FAIL rand[%0d] pc=%h v=%b pc4=%h pend=%b req=%b want pc=%h v=%b pc4=%h pend=%b",
                                        i, pc, valid, pc4, pend, req, m_pc, m_valid, m_pc4, m_pend); end
`ifdef PERF_CNT_EN
            tests++;
            if (miss_cnt !== m_cnt) begin fails++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, miss_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_miss();
        test_branch_complete();
        test_branch_in_miss();
        test_stall_priority();
        test_async_reset();
        stall = 0;
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
